// File: rtl/latch_write_sequencer_if.sv
// Write-request handshake and latch-bank bus
// between a requester and latch_write_sequencer.
interface latch_write_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] latch_d;
  logic             latch_en;
  logic [WIDTH-1:0] latch_q;
  logic             done;
  logic             mismatch;

  modport master (
    output req_valid, req_data, latch_q,
    input  req_ready, latch_d, latch_en,
    input  done, mismatch
  );

  modport slave (
    input  req_valid, req_data, latch_q,
    output req_ready, latch_d, latch_en,
    output done, mismatch
  );
endinterface

// File: rtl/latch_write_sequencer.sv
// Drives a latch bank with setup/pulse/hold
// phasing and checks the readback afterwards.
module latch_write_sequencer #(
  parameter int WIDTH        = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int PULSE_CYCLES = 3,
  parameter int HOLD_CYCLES  = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  latch_write_sequencer_if.slave bus
);

  localparam int MAXP =
    (SETUP_CYCLES > PULSE_CYCLES)
      ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
      : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] S_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_CYCLES - 1);

  if (SETUP_CYCLES < 1 || PULSE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_param
    $error("latch_write_sequencer: phase counts must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] latch_d_q, latch_d_d;
  logic             latch_en_q, latch_en_d;
  logic             req_ready_q, req_ready_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch_d_d   = latch_d_q;
    latch_en_d  = 1'b0;
    req_ready_d = 1'b0;
    done_d      = 1'b0;
    mismatch_d  = mismatch_q;
    unique case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid && req_ready_q) begin
          latch_d_d   = bus.req_data;
          state_d     = SETUP;
          cnt_d       = '0;
          req_ready_d = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == S_LAST) begin
          state_d    = PULSE;
          cnt_d      = '0;
          latch_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PULSE: begin
        latch_en_d = 1'b1;
        if (cnt_q == P_LAST) begin
          state_d    = HOLD;
          cnt_d      = '0;
          latch_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == H_LAST) begin
          // readback uses q as seen at the closing edge
          state_d     = IDLE;
          cnt_d       = '0;
          req_ready_d = 1'b1;
          done_d      = 1'b1;
          mismatch_d  = (bus.latch_q != latch_d_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      latch_d_q   <= '0;
      latch_en_q  <= 1'b0;
      req_ready_q <= 1'b1;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      latch_d_q   <= latch_d_d;
      latch_en_q  <= latch_en_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.latch_d   = latch_d_q;
  assign bus.latch_en  = latch_en_q;
  assign bus.done      = done_q;
  assign bus.mismatch  = mismatch_q;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Randomised and directed bench for latch_write_sequencer
// against a cycle-age reference model and a latch bank.
module tb_latch_write_sequencer;

  localparam int W = 4;
  localparam int S = 2;
  localparam int P = 3;
  localparam int H = 1;
  localparam int T = S + P + H;

  logic clk = 1'b0;
  logic rst_n;
  logic rst8_n;
  always #5 clk = ~clk;

  latch_write_sequencer_if #(.WIDTH(W)) lif ();
  latch_write_sequencer_if #(.WIDTH(8)) lif8 ();

  latch_write_sequencer #(
    .WIDTH(W), .SETUP_CYCLES(S),
    .PULSE_CYCLES(P), .HOLD_CYCLES(H)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(lif.slave)
  );

  latch_write_sequencer #(
    .WIDTH(8), .SETUP_CYCLES(1),
    .PULSE_CYCLES(1), .HOLD_CYCLES(1)
  ) u_dut8 (
    .clk(clk), .rst_n(rst8_n), .bus(lif8.slave)
  );

  // behavioural transparent-latch bank
  logic [W-1:0] bank = '0;
  logic         force_q0 = 1'b0;
  always @* if (lif.latch_en) bank = lif.latch_d;
  assign lif.latch_q  = force_q0 ? '0 : bank;
  assign lif8.latch_q = lif8.latch_d;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  tag, got, exp, $time);
  endtask

  // reference model: age = cycles since acceptance, -1 when idle
  int           age = -1;
  logic [W-1:0] md  = '0;
  logic         mdone = 1'b0;
  logic         mmis  = 1'b0;
  logic [W-1:0] prev_d;
  logic         prev_en = 1'b0;

  task automatic model(input logic v, input logic [W-1:0] data,
                       input logic r, input logic [W-1:0] qs);
    if (!r) begin
      age = -1; md = '0; mdone = 1'b0; mmis = 1'b0;
    end else begin
      mdone = 1'b0;
      if (age < 0) begin
        if (v) begin age = 0; md = data; end
      end else begin
        age++;
        if (age == T) begin
          mdone = 1'b1;
          mmis  = (qs != md);
          age   = -1;
        end
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] data,
                     input logic r);
    logic [W-1:0] qs;
    @(negedge clk);
    rst_n = r;
    lif.req_valid = v;
    lif.req_data  = data;
    prev_d  = lif.latch_d;
    prev_en = lif.latch_en;
    #1 qs = lif.latch_q;
    @(posedge clk);
    #1;
    model(v, data, r, qs);
    chk("ready", 32'(lif.req_ready), 32'(age < 0));
    chk("en", 32'(lif.latch_en), 32'(age >= S && age < S + P));
    chk("d", 32'(lif.latch_d), 32'(md));
    chk("done", 32'(lif.done), 32'(mdone));
    chk("mismatch", 32'(lif.mismatch), 32'(mmis));
    if (prev_en && lif.latch_en)
      chk("d_stable_en", 32'(lif.latch_d), 32'(prev_d));
  endtask

  initial begin
    rst_n = 1'b0;
    rst8_n = 1'b0;
    lif.req_valid = 1'b0;
    lif.req_data = '0;
    lif8.req_valid = 1'b0;
    lif8.req_data = '0;

    // reset with a pending request
    cyc(1'b1, 4'h9, 1'b0);
    cyc(1'b1, 4'h9, 1'b0);
    chk("rst_ready", 32'(lif.req_ready), 32'd1);
    chk("rst_d", 32'(lif.latch_d), 32'd0);

    // single write
    cyc(1'b1, 4'hA, 1'b1);
    repeat (T + 2) cyc(1'b0, 4'h0, 1'b1);

    // readback error then clean write
    force_q0 = 1'b1;
    cyc(1'b1, 4'h5, 1'b1);
    repeat (T) cyc(1'b0, 4'h0, 1'b1);
    chk("forced_mis", 32'(lif.mismatch), 32'd1);
    force_q0 = 1'b0;
    cyc(1'b1, 4'h3, 1'b1);
    repeat (T) cyc(1'b0, 4'h0, 1'b1);
    chk("clean_mis", 32'(lif.mismatch), 32'd0);

    // back-to-back with changing data
    for (int i = 0; i < 2 * (T + 1) + 2; i++)
      cyc(1'b1, 4'(i + 1), 1'b1);
    cyc(1'b0, 4'h0, 1'b1);

    // reset during PULSE
    cyc(1'b1, 4'h7, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0);
    chk("abort_en", 32'(lif.latch_en), 32'd0);
    cyc(1'b1, 4'hC, 1'b1);
    repeat (T + 1) cyc(1'b0, 4'h0, 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      force_q0 = ($urandom_range(0, 7) == 0);
      cyc(1'($urandom_range(0, 1)), 4'($urandom),
          ($urandom_range(0, 39) != 0));
    end
    force_q0 = 1'b0;

    // minimal phasing on the 8-bit instance
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst8_n = 1'b1;
    lif8.req_valid = 1'b1;
    lif8.req_data = 8'hFF;
    @(posedge clk); #1;
    chk("m_acc_ready", 32'(lif8.req_ready), 32'd0);
    chk("m_acc_d", 32'(lif8.latch_d), 32'hFF);
    chk("m_acc_en", 32'(lif8.latch_en), 32'd0);
    @(negedge clk);
    lif8.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("m_e1_en", 32'(lif8.latch_en), 32'd1);
    @(posedge clk); #1;
    chk("m_e2_en", 32'(lif8.latch_en), 32'd0);
    chk("m_e2_done", 32'(lif8.done), 32'd0);
    @(posedge clk); #1;
    chk("m_e3_done", 32'(lif8.done), 32'd1);
    chk("m_e3_ready", 32'(lif8.req_ready), 32'd1);
    chk("m_e3_mis", 32'(lif8.mismatch), 32'd0);
    @(negedge clk);
    lif8.req_valid = 1'b1;
    lif8.req_data = 8'h12;
    @(posedge clk); #1;
    chk("m_e4_ready", 32'(lif8.req_ready), 32'd0);
    chk("m_e4_d", 32'(lif8.latch_d), 32'h12);
    chk("m_e4_done", 32'(lif8.done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/latch_write_sequencer.md
Name: latch_write_sequencer

Overview:
- Upstream driver for a bank of WIDTH d_latch instances.
- Accepts a write request over a valid/ready handshake and presents the data on latch_d.
- Generates a latch_en pulse with a programmable setup/pulse/hold phasing while latch_d is held stable.
- After the hold phase, compares the latch bank's q outputs against the written data and reports done and mismatch.

Parameters:
- WIDTH, 8, number of latches in the driven bank (data width).
- SETUP_CYCLES, 2, cycles latch_d is stable before latch_en rises; legal range >= 1.
- PULSE_CYCLES, 3, cycles latch_en is held high; legal range >= 1.
- HOLD_CYCLES, 1, cycles latch_d is held stable after latch_en falls; legal range >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  1  write request present.
- req_ready  output  1  sequencer can accept a request (high only in IDLE).
- req_data  input  WIDTH  data to write; sampled on handshake only.
- latch_d  output  WIDTH  to the d input of each latch.
- latch_en  output  1  to the en input of every latch.
- latch_q  input  WIDTH  q outputs of the latch bank, used for readback.
- done  output  1  one-cycle pulse: the write sequence has completed.
- mismatch  output  1  result of the last readback: 1 = latch_q differed from latch_d.

Behaviour:
- All outputs are registered; there are no combinational input-to-output paths.
- Reset: rst_n is sampled low at a rising edge. The following edge values apply:
  - state = IDLE, latch_d = 0, latch_en = 0, req_ready = 1, done = 0, mismatch = 0.
  - All phase counters are cleared.
- Reset mid-sequence aborts the write immediately:
  - latch_en drops at that edge.
  - No done pulse is produced.
- States are IDLE, SETUP, PULSE, HOLD.
  - Counter width is clog2 of the largest phase count plus 1.
- IDLE:
  - req_ready = 1, latch_en = 0.
  - A handshake is req_valid && req_ready at an edge; call it edge k.
  - At edge k: latch_d <= req_data, state <= SETUP, req_ready <= 0.
  - Without a handshake, latch_d retains its last value.
- SETUP: lasts SETUP_CYCLES cycles. latch_en <= 1 at edge k+SETUP_CYCLES, and the state becomes PULSE.
- PULSE: latch_en is high for exactly PULSE_CYCLES cycles. latch_en <= 0 at edge k+S+P, and the state becomes HOLD.
- HOLD: lasts HOLD_CYCLES cycles. At edge k+S+P+H:
  - state <= IDLE, req_ready <= 1.
  - done <= 1 for exactly one cycle.
  - mismatch <= (latch_q != latch_d), using latch_q sampled at that edge.
- mismatch holds its value until the next done edge or until reset.
- latch_d is constant from edge k until the next accepted request.
  - It never changes while latch_en is high or during HOLD.
- While busy, req_data and req_valid are ignored; there is no queueing.
- The earliest next accept is edge k+S+P+H+1, which is the cycle in which done is high. The minimum request period is S+P+H+1 cycles.
- latch_en is never high in IDLE, SETUP or HOLD.
- latch_en never glitches; it is driven directly from a flop.
- Out-of-range parameters (any phase count < 1) are illegal. They are flagged by a simulation-time check.

Test Plan:
- Defaults for scenarios 1–5: WIDTH=4, S=2, P=3, H=1.
- Scenario 1, reset: rst_n low for 2 edges with req_valid=1 -> latch_d=0, latch_en=0, req_ready=1, done=0, mismatch=0; nothing is accepted.
- Scenario 2, single write of 4'hA accepted at edge 0, with a behavioural latch bank model:
  - latch_d=4'hA from edge 0.
  - latch_en=1 after edges 2,3,4 and 0 after edge 5.
  - done=1 for one cycle after edge 6, with mismatch=0.
  - req_ready=0 from edge 0 to 5.
- Scenario 3, readback error: force latch_q=4'h0 and write 4'h5 -> mismatch=1 at done. A following normal write of 4'h3 -> mismatch=0 at its done.
- Scenario 4, back-to-back: req_valid held high, req_data changing every cycle -> only the data present at edges 0 and 7 is accepted; latch_d never changes while latch_en=1.
- Scenario 5, reset at edge 3 (PULSE phase) -> latch_en=0, latch_d=0 after edge 3, and no done. A write of 4'hC after release completes normally with mismatch=0.
- Scenario 6, minimal phasing with S=P=H=1 and write 8'hFF at edge 0 -> latch_en high for exactly the cycle after edge 1, done after edge 3, next accept possible at edge 4.
